// File: rtl/restador_serie.sv
// restador_serie: bit-serial N-bit subtractor (A - B, LSB first) with inicio/listo handshake
// Ports: clk, reset (async, active-high), inicio (start), A (minuend), B (subtrahend),
//        resta (registered difference mod 2^N), Bout (registered final borrow, A < B),
//        ocupado (operation in progress), listo (one-cycle result-valid pulse)
module restador_serie #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] resta,
  output logic         Bout,
  output logic         ocupado,
  output logic         listo
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] REPOSO = 2'd0, CALCULO = 2'd1, FIN = 2'd2;
  logic [1:0]    st;
  logic [N-1:0]  ra, rb, rr, nr;
  logic          bw, d, nb;
  logic [CW-1:0] cnt;
  assign d  = ra[0] ^ rb[0] ^ bw;
  assign nb = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bw);
  // nr is the result register after this bit lands, so the completion edge can publish it directly
  assign nr = {d, rr[N-1:1]};
  assign ocupado = st != REPOSO;
  assign listo   = st == FIN;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= REPOSO;
      ra    <= '0;
      rb    <= '0;
      rr    <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      resta <= '0;
      Bout  <= 1'b0;
    end else if (st == REPOSO) begin
      if (inicio) begin
        ra  <= A;
        rb  <= B;
        bw  <= 1'b0;
        cnt <= '0;
        st  <= CALCULO;
      end
    end else if (st == CALCULO) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rr  <= nr;
      bw  <= nb;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        resta <= nr;
        Bout  <= nb;
        st    <= FIN;
      end
    end else begin
      st <= REPOSO;
    end
  end
endmodule

// File: tb/tb_restador_serie.sv
// tb_restador_serie: randomized self-checking bench for restador_serie against an arithmetic model
module tb_restador_serie;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         reset, inicio;
  logic [N-1:0] A, B, resta;
  logic         Bout, ocupado, listo;
  int           n_chk = 0, n_err = 0;
  logic [N-1:0] prev_r;
  logic         prev_b;

  restador_serie #(.N(N)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .A(A), .B(B),
    .resta(resta), .Bout(Bout), .ocupado(ocupado), .listo(listo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; noise injects random start requests while busy, which must be ignored
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input bit noise);
    logic [N-1:0] er;
    logic         eb;
    er = N'((a - b) & ((1 << N) - 1));
    eb = a < b;
    A = a; B = b; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    check("start_busy", ocupado, 1);
    check("start_listo", listo, 0);
    for (int i = 1; i < N; i++) begin
      if (noise) begin
        inicio = 1'b1; A = N'($urandom); B = N'($urandom);
      end
      tick();
      inicio = 1'b0;
      check("hold_resta", resta, prev_r);
      check("hold_bout", Bout, prev_b);
      check("calc_listo", listo, 0);
      check("calc_busy", ocupado, 1);
    end
    tick();
    check("done_listo", listo, 1);
    check("done_busy", ocupado, 1);
    check("resta", resta, er);
    check("bout", Bout, eb);
    if (noise) begin
      inicio = 1'b1; A = N'($urandom); B = N'($urandom);
    end
    tick();
    inicio = 1'b0;
    check("idle_listo", listo, 0);
    check("idle_busy", ocupado, 0);
    check("idle_resta", resta, er);
    prev_r = er;
    prev_b = eb;
  endtask

  initial begin
    reset = 1'b1; inicio = 1'b0; A = '0; B = '0;
    prev_r = '0; prev_b = 1'b0;
    #12;
    check("rst_resta", resta, 0);
    check("rst_bout", Bout, 0);
    check("rst_busy", ocupado, 0);
    check("rst_listo", listo, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    op(4'd9, 4'd3, 0);
    op(4'd3, 4'd9, 0);
    op(4'd0, 4'd1, 0);
    op(4'd15, 4'd15, 0);
    op(4'd0, 4'd0, 0);
    op(4'd15, 4'd0, 0);
    op(4'd12, 4'd5, 1);
    // reset two edges into an operation aborts with no listo
    A = 4'd8; B = 4'd1; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_resta", resta, 0);
    check("abort_bout", Bout, 0);
    check("abort_busy", ocupado, 0);
    check("abort_listo", listo, 0);
    tick();
    reset = 1'b0;
    prev_r = '0; prev_b = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("abort_nolisto", listo, 0);
    end
    op(4'd8, 4'd1, 0);
    // inicio held high: results every N+2 edges, resta holds between completions
    A = 4'd6; B = 4'd2; inicio = 1'b1;
    tick();
    A = 4'd2; B = 4'd6;
    for (int t = 1; t <= 2 * N + 2; t++) begin
      tick();
      check("b2b_listo", listo, (t == N || t == 2 * N + 2) ? 1 : 0);
      check("b2b_busy", ocupado, (t == N + 1) ? 0 : 1);
      check("b2b_resta", resta, t < N ? prev_r : (t < 2 * N + 2 ? 4 : 12));
      check("b2b_bout", Bout, t < N ? prev_b : (t < 2 * N + 2 ? 0 : 1));
    end
    inicio = 1'b0;
    tick();
    check("b2b_end_busy", ocupado, 0);
    prev_r = 4'd12; prev_b = 1'b1;
    for (int k = 0; k < 40; k++)
      op(N'($urandom), N'($urandom), k[0]);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/restador_serie.md
Name: restador_serie

Overview:
- Bit-serial N-bit subtractor. Computes A − B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the subtraction counterpart of the adder chain (sumador_medio / sumador4b). It is used where area matters more than latency.
- Start/done handshake: operands are captured on `inicio`; the result is presented with a one-cycle `listo` pulse.

Parameters:
- N, 4, operand and result width in bits (N ≥ 2).

Ports:
- clk     in   1  system clock, rising edge active
- reset   in   1  asynchronous, active-high reset
- inicio  in   1  start request, sampled on clk rising edge when idle
- A       in   N  minuend, unsigned, sampled with inicio
- B       in   N  subtrahend, unsigned, sampled with inicio
- resta   out  N  difference (A − B) mod 2^N, registered
- Bout    out  1  final borrow: 1 when A < B, registered
- ocupado out  1  high while an operation is in progress (CALCULO or FIN)
- listo   out  1  one-cycle pulse, result valid

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - reset is asynchronous and active-high.
  - While reset is high: state=REPOSO, internal shift registers=0, borrow=0, bit counter=0, resta=0, Bout=0, ocupado=0, listo=0.
- FSM states: REPOSO, CALCULO, FIN.
- REPOSO:
  - ocupado=0, listo=0.
  - On an edge with inicio=1: load regA←A, regB←B, borrow←0, counter←0, then go to CALCULO.
  - With inicio=0: stay in REPOSO.
- CALCULO (ocupado=1), on each edge:
  - d = regA[0] ^ regB[0] ^ borrow
  - borrow ← (~regA[0] & regB[0]) | (~(regA[0] ^ regB[0]) & borrow)
  - regA and regB shift right by 1; d shifts into the MSB of the internal result register.
  - counter increments.
  - On the edge that processes bit N−1 (counter = N−1): copy the completed result to resta, copy the final borrow to Bout, go to FIN.
- FIN:
  - ocupado=1, listo=1 (Moore output), lasting exactly one cycle.
  - Next edge: go to REPOSO unconditionally.
- Latency:
  - inicio sampled at edge E0 → bits processed at E1..EN → resta/Bout update at EN.
  - listo is high from EN to EN+1; ocupado is high from E0 to EN+1.
  - Total: N+1 cycles from start edge to end of listo pulse.
- Output hold:
  - resta and Bout change only at completion edges (or reset).
  - They hold their values between operations; internal partial results are never visible on resta.
- Handshake rules:
  - inicio is ignored while ocupado=1, including in FIN. A and B may change freely after E0.
  - inicio=1 in the cycle after FIN (state REPOSO) starts a new operation, so back-to-back throughput is one result per N+2 cycles.
  - Holding inicio high continuously restarts an operation every N+2 cycles.
- Arithmetic:
  - Unsigned modulo 2^N. resta equals the N-bit two's-complement difference.
  - Bout=1 if and only if A < B. A=B gives resta=0, Bout=0.
- Reset mid-operation: aborts immediately with no listo pulse. resta/Bout return to 0 and the FSM returns to REPOSO. The first inicio after release starts cleanly.
- Counter width: ceil(log2(N)) bits; no wrap-around reachable beyond N−1.

Test Plan (N=4):
- Reset, then A=9, B=3, inicio for one cycle → after 4 edges resta=6, Bout=0; listo high exactly 1 cycle; ocupado high 5 cycles.
- A=3, B=9 → resta=10 (4'b1010), Bout=1. A=0, B=1 → resta=15, Bout=1.
- Boundaries: A=15, B=15 → resta=0, Bout=0. A=0, B=0 → resta=0, Bout=0. A=15, B=0 → resta=15, Bout=0.
- Start A=12, B=5; pulse inicio with A=1, B=2 during CALCULO and during FIN → second request ignored; resta=7, Bout=0; a single listo pulse.
- Assert reset two cycles into an operation with A=8, B=1 → outputs 0 immediately, no listo. Release, start A=8, B=1 → resta=7, Bout=0.
- Back-to-back: inicio held high with A=6, B=2 then A=2, B=6 → resta=4, Bout=0, then resta=12, Bout=1. listo pulses are 6 cycles apart; resta holds 4 until the second completion edge.
